// File: rtl/seg_display_master.sv
// Avalon-MM master that pushes a prescaled BCD/binary counter into a segment-display slave register.
// Defining SEG_READBACK_VERIFY_EN adds a readback check after every write (sticky verify_error).
module seg_display_master #(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter logic [3:0]  TARGET_ADDR  = 4'h0,
    parameter logic [3:0]  BYTE_EN      = 4'hF,
    parameter bit          BCD_MODE     = 1'b1,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    output logic [3:0]  master_address,
    output logic        master_write,
    output logic        master_read,
    output logic [31:0] master_writedata,
    output logic [3:0]  master_byteenable,
    input  logic [31:0] master_readdata,
    input  logic        master_waitrequest,
    output logic [31:0] count_value,
    output logic        busy,
    output logic        verify_error
);
    localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1'b1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(1'b0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RWAIT = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [PW-1:0] presc_r;
    logic [31:0]   count_r;
    logic [31:0]   wdata_r;
    logic          pending_r;
    logic          tick_s;
    logic          latch_s;
    logic          write_s;
    logic          read_s;
    logic          master_write_r;
    logic [3:0]    master_address_r;
    logic [3:0]    master_byteenable_r;
    logic          busy_r;

    // Next counter value: decimal ripple per nibble in BCD mode, plain increment otherwise.
    function automatic logic [31:0] next_count(input logic [31:0] cur);
        logic [31:0] res;
        logic        carry;
        res   = cur;
        carry = 1'b1;
        if (BCD_MODE) begin
            for (int i = 0; i < 8; i++) begin
                if (carry && (cur[4*i +: 4] >= 4'd9)) begin
                    res[4*i +: 4] = 4'd0;
                end else if (carry) begin
                    res[4*i +: 4] = cur[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end else begin
                    res[4*i +: 4] = cur[4*i +: 4];
                end
            end
        end else begin
            res = cur + 32'd1;
        end
        return res;
    endfunction

    assign tick_s = enable && (presc_r == PRESC_LAST);

    // Prescaler and display counter; clear outranks a coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r <= PRESC_ZERO;
            count_r <= 32'd0;
        end else if (clear) begin
            presc_r <= PRESC_ZERO;
            count_r <= 32'd0;
        end else if (tick_s) begin
            presc_r <= PRESC_ZERO;
            count_r <= next_count(count_r);
        end else if (enable) begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    // Pending write request; a fresh tick/clear wins over the FSM consuming the old one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 1'b1;
        end else if (clear || tick_s) begin
            pending_r <= 1'b1;
        end else if (latch_s) begin
            pending_r <= 1'b0;
        end
    end

`ifdef SEG_READBACK_VERIFY_EN
    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

    logic [2:0] lat_r;
    logic       sample_s;
    logic       master_read_r;
    logic       verify_error_r;
`else
    assign read_s = 1'b0;
`endif

    // Next-state and request decode; a request drops the cycle after it is accepted.
    always_comb begin
        state_s = state_r;
        latch_s = 1'b0;
        write_s = 1'b0;
`ifdef SEG_READBACK_VERIFY_EN
        read_s   = 1'b0;
        sample_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (pending_r) begin
                    latch_s = 1'b1;
                    state_s = WRITE;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (master_write_r && !master_waitrequest) begin
`ifdef SEG_READBACK_VERIFY_EN
                    state_s = READ;
`else
                    state_s = IDLE;
`endif
                end else begin
                    write_s = 1'b1;
                end
            end
`ifdef SEG_READBACK_VERIFY_EN
            READ: begin
                if (master_read_r && !master_waitrequest) begin
                    state_s = RWAIT;
                end else begin
                    read_s = 1'b1;
                end
            end
            RWAIT: begin
                if (lat_r == LAT_LAST) begin
                    sample_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = RWAIT;
                end
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r             <= IDLE;
            master_write_r      <= 1'b0;
            master_address_r    <= 4'h0;
            master_byteenable_r <= 4'h0;
            wdata_r             <= 32'd0;
            busy_r              <= 1'b0;
        end else begin
            state_r             <= state_s;
            master_write_r      <= write_s;
            master_address_r    <= (write_s || read_s) ? TARGET_ADDR : 4'h0;
            master_byteenable_r <= (write_s || read_s) ? BYTE_EN : 4'h0;
            busy_r              <= (state_s != IDLE);
            if (latch_s) begin
                wdata_r <= count_r;
            end
        end
    end

`ifdef SEG_READBACK_VERIFY_EN
    // Read request, latency counter and sticky mismatch flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            master_read_r  <= 1'b0;
            lat_r          <= 3'd0;
            verify_error_r <= 1'b0;
        end else begin
            master_read_r <= read_s;
            lat_r         <= ((state_r == RWAIT) && !sample_s) ? lat_r + 3'd1 : 3'd0;
            if (sample_s && (master_readdata != wdata_r)) begin
                verify_error_r <= 1'b1;
            end
        end
    end

    assign master_read  = master_read_r;
    assign verify_error = verify_error_r;
`else
    logic unused_s;
    assign unused_s     = ^{master_readdata, READ_LATENCY[2:0]};
    assign master_read  = 1'b0;
    assign verify_error = 1'b0;
`endif

    assign master_write      = master_write_r;
    assign master_address    = master_address_r;
    assign master_byteenable = master_byteenable_r;
    assign master_writedata  = wdata_r;
    assign count_value       = count_r;
    assign busy              = busy_r;
endmodule
